// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch slice.
// FSM states, default reset address and the prefetch queue entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch queue of {word, pc} entries.
// Flush clears the queue and wins over a same-cycle push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot, so pop+push is accepted even when full.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential prefetcher feeding Instr/IRWrite to the controller.
// Define FETCH_PERF_EN to add the StallCount/FlushCount performance ports.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic [31:0] PCNext,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   req_pc_q;
    logic [31:0]   req_pc_d;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          outstanding;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    entry_t        head;
    entry_t        push_entry;

    assign push_entry.word = ImemRData;
    assign push_entry.pc   = req_pc_q;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (PCWrite),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign outstanding = (state_q != FETCH);
    assign occ         = {1'b0, count} + (CW + 1)'(outstanding);
    assign pop         = IRWrite & ~empty & ~PCWrite;
    assign InstrValid  = ~empty;
    assign Instr       = empty ? '0 : head.word;
    assign InstrPC     = empty ? '0 : head.pc;
    assign ImemAddr    = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        ImemReq    = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            FETCH: begin
                ImemReq = reset & ~full & (occ < (CW + 1)'(DEPTH));
                if (ImemReq && ImemGnt) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (ImemRValid) begin
                    push    = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (ImemRValid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // A response landing in the redirect cycle is dropped and ends the wait.
        if (PCWrite) begin
            push       = 1'b0;
            fetch_pc_d = word_align(PCNext);
            if (ImemReq && ImemGnt)
                state_d = DRAIN;
            else if (outstanding && !ImemRValid)
                state_d = DRAIN;
            else
                state_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= word_align(RESET_PC);
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!InstrValid && StallCount != '1)
                StallCount <= StallCount + 32'd1;
            if (PCWrite && FlushCount != '1)
                FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Memory responder answers each issue after `lat` cycles with mw(addr).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IRWrite = 1'b0;
    logic        PCWrite = 1'b0;
    logic [31:0] PCNext = '0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt = 1'b1;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          issues = 0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCNext     (PCNext),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRValid (ImemRValid),
        .ImemRData  (ImemRData)
`ifdef FETCH_PERF_EN
        ,
        .StallCount (StallCount),
        .FlushCount (FlushCount)
`endif
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    initial begin : memory
        forever begin
            @(posedge clk);
            #3;
            ImemRValid = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        ImemRValid = 1'b1;
                        ImemRData  = mw(paddr);
                        pend       = 1'b0;
                    end
                end
                if (ImemReq && ImemGnt) begin
                    pend  = 1'b1;
                    paddr = ImemAddr;
                    cnt   = lat;
                    issues++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCNext  = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (InstrValid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b want 0", InstrValid);
        end
        checks++;
        if (ImemReq !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: got %b want 0", ImemReq);
        end
        checks++;
        if (Instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_instr: got %h want 0", Instr);
        end
        checks++;
        if (InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc: got %h want 0", InstrPC);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_first_req: got %b/%h want 1/0", ImemReq, ImemAddr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int          got;
        exp     = 32'h0;
        got     = 0;
        IRWrite = 1'b1;
        for (int i = 0; i < 40 && got < 10; i++) begin
            if (InstrValid) begin
                checks++;
                if (InstrPC !== exp) begin
                    errors++;
                    $display("FAIL stream_pc: got %h want %h", InstrPC, exp);
                end
                checks++;
                if (Instr !== mw(exp)) begin
                    errors++;
                    $display("FAIL stream_word: got %h want %h", Instr, mw(exp));
                end
                exp += 32'd4;
                got++;
            end
            tick();
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL stream_count: got %0d want 10", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int          got;
        int          base;
        lat = 1;
        apply_reset();
        base = issues;
        repeat (10) tick();
        checks++;
        if (issues - base != 2) begin
            errors++;
            $display("FAIL bp_issues: got %0d want 2", issues - base);
        end
        checks++;
        if (ImemReq !== 1'b0) begin
            errors++;
            $display("FAIL bp_req: got %b want 0", ImemReq);
        end
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL bp_head: got %b/%h want 1/0", InstrValid, InstrPC);
        end
        exp     = 32'h0;
        got     = 0;
        IRWrite = 1'b1;
        for (int i = 0; i < 40 && got < 6; i++) begin
            if (InstrValid) begin
                checks++;
                if (InstrPC !== exp || Instr !== mw(exp)) begin
                    errors++;
                    $display("FAIL bp_resume: got %h/%h want %h/%h",
                             InstrPC, Instr, exp, mw(exp));
                end
                exp += 32'd4;
                got++;
            end
            tick();
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d want 6", got);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        lat = 3;
        apply_reset();
        IRWrite = 1'b1;
        tick();
        PCWrite = 1'b1;
        PCNext  = 32'h100;
        tick();
        PCWrite = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || ImemReq !== 1'b0) begin
            errors++;
            $display("FAIL rw_drain: got valid=%b req=%b want 0/0", InstrValid, ImemReq);
        end
        checks++;
        if (ImemAddr !== 32'h100) begin
            errors++;
            $display("FAIL rw_addr: got %h want 00000100", ImemAddr);
        end
        wait_valid(30, ok);
        checks++;
        if (!ok || InstrPC !== 32'h100 || Instr !== mw(32'h100)) begin
            errors++;
            $display("FAIL rw_first: got ok=%b %h/%h want 00000100/%h",
                     ok, InstrPC, Instr, mw(32'h100));
        end
        tick();
        wait_valid(30, ok);
        checks++;
        if (!ok || InstrPC !== 32'h104) begin
            errors++;
            $display("FAIL rw_second: got ok=%b %h want 00000104", ok, InstrPC);
        end
    endtask

    task automatic test_redirect_rvalid();
        bit ok;
        lat = 1;
        apply_reset();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (InstrValid && !ImemReq) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_setup: got timeout want wait state");
        end
        PCWrite = 1'b1;
        PCNext  = 32'h100;
        IRWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        IRWrite = 1'b0;
        checks++;
        if (InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL rr_flush: got %b want 0", InstrValid);
        end
        checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin
            errors++;
            $display("FAIL rr_req: got %b/%h want 1/00000100", ImemReq, ImemAddr);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || InstrPC !== 32'h100 || Instr !== mw(32'h100)) begin
            errors++;
            $display("FAIL rr_first: got ok=%b %h/%h want 00000100", ok, InstrPC, Instr);
        end
    endtask

    task automatic test_wrap_reset();
        bit ok;
        lat = 1;
        apply_reset();
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        PCNext  = 32'hFFFF_FFFF;
        tick();
        PCWrite = 1'b0;
        checks++;
        if (ImemAddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_align: got %h want fffffffc", ImemAddr);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || InstrPC !== 32'hFFFF_FFFC || Instr !== mw(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_word: got ok=%b %h/%h want fffffffc", ok, InstrPC, Instr);
        end
        checks++;
        if (ImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000000", ImemAddr);
        end
        tick();
        wait_valid(20, ok);
        checks++;
        if (!ok || InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got ok=%b %h want 00000000", ok, InstrPC);
        end
        lat     = 3;
        IRWrite = 1'b0;
        PCWrite = 1'b1;
        PCNext  = 32'h200;
        tick();
        PCWrite = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ImemReq && ImemAddr == 32'h200) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_setup: got timeout want req to 00000200");
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got %b/%b/%h want 0/1/00000000",
                     InstrValid, ImemReq, ImemAddr);
        end
        wait_valid(30, ok);
        checks++;
        if (!ok || InstrPC !== 32'h0 || Instr !== mw(32'h0)) begin
            errors++;
            $display("FAIL mid_first: got ok=%b %h/%h want 00000000", ok, InstrPC, Instr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        lat = 3;
        apply_reset();
        checks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: got %0d/%0d want 0/0", StallCount, FlushCount);
        end
        repeat (8) tick();
        checks++;
        if (StallCount !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall: got %0d want 4", StallCount);
        end
        PCWrite = 1'b1;
        PCNext  = 32'h300;
        tick();
        checks++;
        if (StallCount !== 32'd4 || FlushCount !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush1: got %0d/%0d want 4/1", StallCount, FlushCount);
        end
        tick();
        PCWrite = 1'b0;
        checks++;
        if (StallCount !== 32'd5 || FlushCount !== 32'd2) begin
            errors++;
            $display("FAIL perf_flush2: got %0d/%0d want 5/2", StallCount, FlushCount);
        end
    endtask
`endif

    initial begin : main
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
